// File: rtl/gsm_at_script_tx.sv
// Script-driven UART sender for GSM AT commands: fetches words from a synchronous
// script memory, sends each byte as a UART frame, and inserts idle gaps after command ends.
// Optional macro GSM_AT_PARITY_EN adds an even-parity bit before the stop bit.
module gsm_at_script_tx #(
  parameter int CLK_DIV   = 5208,
  parameter int DELAY_CYC = 12000000,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              script_rd,
  output logic [ADDR_W-1:0] script_addr,
  input  logic [9:0]        script_data,
  output logic              line_tx,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

`ifdef GSM_AT_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(DELAY_CYC - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAITD, SEND, GAP, DONE} state_t;

  state_t                state;
  logic [BW-1:0]         baud_cnt;
  logic [DW-1:0]         gap_cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] frame;
  logic                  cmd_end;
  logic                  script_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      gap_cnt     <= '0;
      bit_idx     <= '0;
      frame       <= '1;
      cmd_end     <= 1'b0;
      script_end  <= 1'b0;
      script_rd   <= 1'b0;
      script_addr <= '0;
      line_tx     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      script_rd <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      if (abort && state != IDLE) begin
        // Abort wins over everything, truncating any frame on the line.
        state    <= IDLE;
        line_tx  <= 1'b1;
        busy     <= 1'b0;
        aborted  <= 1'b1;
        baud_cnt <= '0;
        gap_cnt  <= '0;
        bit_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              script_addr <= start_addr;
              script_rd   <= 1'b1;
              busy        <= 1'b1;
              state       <= FETCH;
            end
          end
          FETCH: state <= WAITD;
          WAITD: begin
            // Frame is shifted out LSB first; bit 0 (start) goes on the line now.
`ifdef GSM_AT_PARITY_EN
            frame <= {1'b1, ^script_data[7:0], script_data[7:0], 1'b0};
`else
            frame <= {1'b1, script_data[7:0], 1'b0};
`endif
            cmd_end    <= script_data[8];
            script_end <= script_data[9];
            line_tx    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= SEND;
          end
          SEND: begin
            if (baud_cnt == BAUD_LAST) begin
              baud_cnt <= '0;
              if (bit_idx == LAST_BIT) begin
                line_tx <= 1'b1;
                bit_idx <= '0;
                if (script_end || cmd_end) begin
                  gap_cnt <= '0;
                  state   <= GAP;
                end else begin
                  script_addr <= script_addr + 1'b1;
                  script_rd   <= 1'b1;
                  state       <= FETCH;
                end
              end else begin
                bit_idx <= bit_idx + 4'd1;
                line_tx <= frame[1];
                frame   <= {1'b1, frame[FRAME_BITS-1:1]};
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              if (script_end) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                script_addr <= script_addr + 1'b1;
                script_rd   <= 1'b1;
                state       <= FETCH;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gsm_at_script_tx.sv
// Bench for gsm_at_script_tx: expected line/status traces are built per cycle from
// the script contents and framing rules, then compared against the DUT.
module tb_gsm_at_script_tx;
  localparam int CLK_DIV   = 4;
  localparam int DELAY_CYC = 10;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
`ifdef GSM_AT_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [ADDR_W-1:0] start_addr;
  logic              script_rd;
  logic [ADDR_W-1:0] script_addr;
  logic [9:0]        script_data;
  logic              line_tx, busy, done, aborted;

  gsm_at_script_tx #(.CLK_DIV(CLK_DIV), .DELAY_CYC(DELAY_CYC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .abort(abort),
    .script_rd(script_rd), .script_addr(script_addr), .script_data(script_data),
    .line_tx(line_tx), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [DEPTH];
  initial script_data = '0;
  always @(posedge clk) if (script_rd) script_data <= mem[script_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle outputs {line_tx, busy, done, aborted, script_rd} and read address.
  logic [4:0]        eq [$];
  logic [ADDR_W-1:0] ea [$];
  logic [4:0]        obs;

  task automatic push(input logic l, input logic b, input logic d, input logic r, input int a);
    eq.push_back({l, b, d, 1'b0, r});
    ea.push_back(ADDR_W'(a));
  endtask

  // Reference: two fetch cycles, NBITS bits of CLK_DIV cycles, optional gap, then next/done.
  task automatic build(input int sa, input int cap);
    int a;
    logic [9:0] w;
    logic v;
    eq.delete(); ea.delete();
    a = sa;
    push(1, 1, 0, 1, a); push(1, 1, 0, 0, 0);
    forever begin
      w = mem[a];
      for (int b = 0; b < NBITS; b++) begin
        if (b == 0) v = 1'b0;
        else if (b <= 8) v = w[b-1];
        else if (NBITS == 11 && b == 9) v = ^w[7:0];
        else v = 1'b1;
        repeat (CLK_DIV) push(v, 1, 0, 0, 0);
      end
      if (w[9] || w[8]) repeat (DELAY_CYC) push(1, 1, 0, 0, 0);
      if (w[9]) begin
        push(1, 0, 1, 0, 0);
        repeat (3) push(1, 0, 0, 0, 0);
        break;
      end
      a = (a + 1) % DEPTH;
      push(1, 1, 0, 1, a); push(1, 1, 0, 0, 0);
      if (eq.size() > cap) break;
    end
  endtask

  task automatic load_at;
    for (int i = 0; i < DEPTH; i++) mem[i] = 10'h000;
    mem[0] = 10'h041;
    mem[1] = 10'h054;
    mem[2] = 10'h30D;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {line_tx, busy, done, aborted, script_rd};
    n_cmp++;
    if (obs !== 5'b10000) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", obs, 5'b10000); end
    n_cmp++;
    if (script_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", script_addr); end
    rst = 1'b0;
    @(negedge clk);
    obs = {line_tx, busy, done, aborted, script_rd};
    n_cmp++;
    if (obs !== 5'b10000) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs, 5'b10000); end
  endtask

  task automatic test_at_script;
    load_at();
    build(0, 2000);
    @(negedge clk); start = 1'b1; start_addr = 4'd0;
    for (int k = 0; k < eq.size(); k++) begin
      @(negedge clk); start = 1'b0;
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== eq[k]) begin n_bad++; $display("FAIL at_script cyc %0d: got %b want %b", k, obs, eq[k]); end
      if (eq[k][0]) begin
        n_cmp++;
        if (script_addr !== ea[k]) begin n_bad++; $display("FAIL at_script_addr cyc %0d: got %0d want %0d", k, script_addr, ea[k]); end
      end
    end
  endtask

  task automatic test_gap;
    for (int i = 0; i < DEPTH; i++) mem[i] = 10'h000;
    mem[5] = 10'h149;
    mem[6] = 10'h245;
    build(5, 2000);
    @(negedge clk); start = 1'b1; start_addr = 4'd5;
    for (int k = 0; k < eq.size(); k++) begin
      @(negedge clk); start = 1'b0;
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== eq[k]) begin n_bad++; $display("FAIL gap cyc %0d: got %b want %b", k, obs, eq[k]); end
      if (eq[k][0]) begin
        n_cmp++;
        if (script_addr !== ea[k]) begin n_bad++; $display("FAIL gap_addr cyc %0d: got %0d want %0d", k, script_addr, ea[k]); end
      end
    end
  endtask

  // Abort lands in the third data bit of 'T' (cycles 56..59 of the trace).
  task automatic test_abort;
    load_at();
    build(0, 2000);
    @(negedge clk); start = 1'b1; start_addr = 4'd0;
    for (int k = 0; k <= 57; k++) begin
      @(negedge clk); start = 1'b0;
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== eq[k]) begin n_bad++; $display("FAIL abort_pre cyc %0d: got %b want %b", k, obs, eq[k]); end
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    obs = {line_tx, busy, done, aborted, script_rd};
    n_cmp++;
    if (obs !== 5'b10010) begin n_bad++; $display("FAIL abort_take: got %b want %b", obs, 5'b10010); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== 5'b10000) begin n_bad++; $display("FAIL abort_after cyc %0d: got %b want %b", k, obs, 5'b10000); end
    end
    @(negedge clk); start = 1'b1; start_addr = 4'd0;
    for (int k = 0; k < eq.size(); k++) begin
      @(negedge clk); start = 1'b0;
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== eq[k]) begin n_bad++; $display("FAIL abort_restart cyc %0d: got %b want %b", k, obs, eq[k]); end
    end
  endtask

  task automatic test_busy_start;
    load_at();
    mem[9] = 10'h35A;
    build(0, 2000);
    @(negedge clk); start = 1'b1; start_addr = 4'd0;
    for (int k = 0; k < eq.size(); k++) begin
      @(negedge clk);
      start = (k == 20 || k == 43 || k == 110);
      start_addr = start ? 4'd9 : 4'd0;
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== eq[k]) begin n_bad++; $display("FAIL busy_start cyc %0d: got %b want %b", k, obs, eq[k]); end
      if (eq[k][0]) begin
        n_cmp++;
        if (script_addr !== ea[k]) begin n_bad++; $display("FAIL busy_start_addr cyc %0d: got %0d want %0d", k, script_addr, ea[k]); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < DEPTH; i++) mem[i] = 10'($urandom_range(0, 255));
    build(14, 300);
    @(negedge clk); start = 1'b1; start_addr = 4'd14;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); start = 1'b0;
      obs = {line_tx, busy, done, aborted, script_rd};
      n_cmp++;
      if (obs !== eq[k]) begin n_bad++; $display("FAIL wrap cyc %0d: got %b want %b", k, obs, eq[k]); end
      if (eq[k][0]) begin
        n_cmp++;
        if (script_addr !== ea[k]) begin n_bad++; $display("FAIL wrap_addr cyc %0d: got %0d want %0d", k, script_addr, ea[k]); end
      end
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    obs = {line_tx, busy, done, aborted, script_rd};
    n_cmp++;
    if (obs !== 5'b10010) begin n_bad++; $display("FAIL wrap_abort: got %b want %b", obs, 5'b10010); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    int sa, len, k_ab;
    bit do_ab;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = {1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
      sa  = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 4);
      mem[(sa + len) % DEPTH][9] = 1'b1;
      build(sa, 4000);
      do_ab = ($urandom_range(0, 3) == 0);
      k_ab  = $urandom_range(0, eq.size() - 5);
      @(negedge clk); start = 1'b1; start_addr = ADDR_W'(sa);
      for (int k = 0; k < eq.size(); k++) begin
        @(negedge clk); start = 1'b0;
        obs = {line_tx, busy, done, aborted, script_rd};
        n_cmp++;
        if (obs !== eq[k]) begin n_bad++; $display("FAIL random it %0d cyc %0d: got %b want %b", it, k, obs, eq[k]); end
        if (eq[k][0]) begin
          n_cmp++;
          if (script_addr !== ea[k]) begin n_bad++; $display("FAIL random_addr it %0d cyc %0d: got %0d want %0d", it, k, script_addr, ea[k]); end
        end
        if (do_ab && k == k_ab) begin
          abort = 1'b1;
          @(negedge clk); abort = 1'b0;
          obs = {line_tx, busy, done, aborted, script_rd};
          n_cmp++;
          if (obs !== 5'b10010) begin n_bad++; $display("FAIL random_abort it %0d: got %b want %b", it, obs, 5'b10010); end
          repeat (3) begin
            @(negedge clk);
            obs = {line_tx, busy, done, aborted, script_rd};
            n_cmp++;
            if (obs !== 5'b10000) begin n_bad++; $display("FAIL random_post_abort it %0d: got %b want %b", it, obs, 5'b10000); end
          end
          break;
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    bit seen;
    load_at();
    seen = 1'b0;
    @(negedge clk); start = 1'b1; start_addr = 4'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); start = 1'b0;
      if (line_tx === 1'b0) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL midframe_start: got no start bit want line low within 20 cycles"); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    obs = {line_tx, busy, done, aborted, script_rd};
    n_cmp++;
    if (obs !== 5'b10000) begin n_bad++; $display("FAIL midframe_reset: got %b want %b", obs, 5'b10000); end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    obs = {line_tx, busy, done, aborted, script_rd};
    n_cmp++;
    if (obs !== 5'b10000) begin n_bad++; $display("FAIL midframe_idle: got %b want %b", obs, 5'b10000); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 10'h000;
    test_reset();
    test_at_script();
    test_gap();
    test_abort();
    test_busy_start();
    test_wrap();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gsm_at_script_tx.md
Name: gsm_at_script_tx

Overview:
- Parametrised successor to the fixed-string GSM AT-command UART sender.
- Plays a byte script from an external synchronous memory as 8-bit UART frames on `line_tx`.
- Inserts a programmable inter-command gap after each end-of-command byte.
- Supports several scripts in one memory, selected by start address (call, SMS, status query), plus abort and busy/done status. Sits between the key/alarm logic and the GSM modem RX pin.

Parameters:
- CLK_DIV, 5208: clk cycles per UART bit (9600 baud at 50 MHz); legal range ≥ 2.
- DELAY_CYC, 12000000: clk cycles of idle-high gap after a CMD_END byte.
- ADDR_W, 8: script memory address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begin script at `start_addr`
- start_addr  in  ADDR_W  first script word address, sampled with `start`
- abort  in  1  one-cycle pulse; stop immediately
- script_rd  out  1  memory read strobe, one cycle
- script_addr  out  ADDR_W  memory read address
- script_data  in  10  word: [7:0] byte, [8] CMD_END, [9] SCRIPT_END; valid the cycle after `script_rd`
- line_tx  out  1  UART TX, idle high
- busy  out  1  high from the cycle after accepted `start` until DONE/abort
- done  out  1  one-cycle pulse at normal script completion
- aborted  out  1  one-cycle pulse when an abort is taken

Behaviour:
- Reset values: line_tx=1, busy=0, done=0, aborted=0, script_rd=0, script_addr=0, state IDLE.
- States: IDLE, FETCH, WAITD, SEND, GAP, DONE.
- IDLE: `start` latches `start_addr` into script_addr, moves to FETCH, sets busy. `start` in any other state is ignored.
- FETCH: script_rd=1 for one cycle, then WAITD.
- WAITD: latches script_data into the byte and flag registers, then SEND.
- Latency: the start bit begins 3 cycles after the `start` pulse. Between bytes, the next start bit begins 2 cycles after the previous stop bit ends.
- SEND frame: start bit 0, data[0..7] LSB first, stop bit 1. Each bit lasts exactly CLK_DIV cycles, so a frame is 10*CLK_DIV cycles.
- End of frame routing:
  - SCRIPT_END set: go to GAP, then DONE. SCRIPT_END takes priority over CMD_END, and the gap is always applied.
  - CMD_END set: go to GAP, then script_addr+1, FETCH.
  - Neither set: script_addr+1, FETCH.
- GAP: line_tx=1 for exactly DELAY_CYC cycles. The bit counter is held at 0.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A script_addr increment at 2^ADDR_W-1 wraps to 0 with no error flag; scripts are responsible for terminating.
- abort, any non-IDLE state:
  - Next cycle: line_tx=1, busy=0, aborted=1 for one cycle, IDLE. No done pulse.
  - A frame in progress is truncated.
  - abort in IDLE is ignored.
- Simultaneous `start` and `abort` in IDLE: both ignored.
- Asynchronous reset mid-frame forces line_tx high immediately.
- Counter widths sized with `$clog2` of CLK_DIV and DELAY_CYC. No counter may overflow at maximum parameter values.

Optional Feature:
- Macro GSM_AT_PARITY_EN.
- Defined: an even-parity bit (XOR of data[7:0]) is inserted between data[7] and the stop bit. The frame becomes 11*CLK_DIV cycles.
- Undefined: 8N1 framing only, and no parity logic is present.

Test Plan (CLK_DIV=4, DELAY_CYC=10, ADDR_W=4):
- 1. Memory[0..2]="AT",0x0D|CMD_END|SCRIPT_END; start, start_addr=0 → line_tx emits 0x41, 0x54, 0x0D at 4 cycles/bit; start bits 2 cycles apart after each stop bit; 10-cycle gap; done pulse once; busy low after.
- 2. Memory[5]="I"|CMD_END, [6]="E"|SCRIPT_END; start_addr=5 → exactly 10 idle-high cycles between the 'I' stop bit and the 2-cycle fetch before 'E'. script_addr sequence is 5, 6.
- 3. abort during the third data bit of byte 0x54 → next cycle line_tx=1, aborted=1, busy=0, no done. A new start then works normally.
- 4. Second `start` pulse while busy, with a different start_addr → ignored; script_addr sequence unchanged.
- 5. Script without SCRIPT_END, starting at 14 → script_addr runs 14, 15, 0 (wrap); abort stops it.
- 6. GSM_AT_PARITY_EN defined, byte 0x41 → frame 0, 1000 0010, parity 0, stop 1; total 44 cycles. Byte 0x43 → parity 1.
